// File: rtl/factorial_core.sv
// Sequential N! engine: reads N from the register file, runs one 128x64 multiply per
// cycle, and writes the 128-bit result back as high/low words. Optional status write: FACT_STATUS_WB_EN.
module factorial_core #(
  parameter logic [2:0]  ADDR_OPERAND = 3'd1,
  parameter logic [2:0]  ADDR_RES_H   = 3'd2,
  parameter logic [2:0]  ADDR_RES_L   = 3'd3,
  parameter logic [2:0]  ADDR_STATUS  = 3'd4,
  parameter int unsigned MAX_N        = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [2:0]  rd_addr,
  input  logic [63:0] rd_data,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [63:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_MUL, S_WR_H, S_WR_L, S_WR_S, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   acc_q, acc_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           error_q, error_d;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          error_d = 1'b0;
        end
      end
      S_READ: begin
        if (rd_data > 64'(MAX_N)) begin
          acc_d   = '0;
          error_d = 1'b1;
          state_d = S_WR_H;
        end else if (rd_data <= 64'd1) begin
          acc_d   = 128'd1;
          state_d = S_WR_H;
        end else begin
          acc_d   = 128'd1;
          cnt_d   = rd_data[5:0];
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // Counts down N..2 multiplying, then one cycle at cnt==1 to leave.
        if (cnt_q > 6'd1) begin
          acc_d = acc_q * 128'(cnt_q);
          cnt_d = cnt_q - 6'd1;
        end else begin
          state_d = S_WR_H;
        end
      end
      S_WR_H: state_d = S_WR_L;
`ifdef FACT_STATUS_WB_EN
      S_WR_L: state_d = S_WR_S;
      S_WR_S: state_d = S_DONE;
`else
      S_WR_L: state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: decoded purely from registered state and accumulator.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 64'd0;
    case (state_q)
      S_WR_H: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_RES_H;
        wr_data = acc_q[127:64];
      end
      S_WR_L: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_RES_L;
        wr_data = acc_q[63:0];
      end
`ifdef FACT_STATUS_WB_EN
      S_WR_S: begin
        wr_en   = 1'b1;
        wr_addr = ADDR_STATUS;
        wr_data = {62'd0, error_q, 1'b1};
      end
`endif
      default: ;
    endcase
  end

  assign rd_addr = ADDR_OPERAND;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign error   = error_q;

endmodule
